// File: rtl/handshake_rr_arbiter.sv
// N-to-1 round-robin valid/ready arbiter with packet lock and a registered
// main + skid output stage, so every downstream-facing output comes from a flop.
module handshake_rr_arbiter #(
    parameter int N  = 4,
    parameter int DW = 8,
    parameter int SW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N-1:0]    valid_pre_i,
    input  logic [N-1:0]    last_pre_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N-1:0]    ready_pre_o,
    output logic            valid_post_o,
    output logic [DW-1:0]   data_o,
    output logic [SW-1:0]   src_o,
    output logic            last_o,
    input  logic            ready_post_i
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t        state_reg;
    state_t        state_next;
    logic [SW-1:0] rr_ptr_reg;
    logic [SW-1:0] rr_ptr_next;
    logic [SW-1:0] owner_reg;
    logic [SW-1:0] owner_next;

    logic [SW-1:0] winner;
    logic          winner_valid;
    logic [SW:0]   scan_idx;
    logic [SW-1:0] scan_sel;

    logic          accept;
    logic [DW-1:0] acc_data;
    logic          acc_last;

    logic          main_valid_reg;
    logic [DW-1:0] main_data_reg;
    logic [SW-1:0] main_src_reg;
    logic          main_last_reg;
    logic          skid_valid_reg;
    logic [DW-1:0] skid_data_reg;
    logic [SW-1:0] skid_src_reg;
    logic          skid_last_reg;
    logic          drain;

    // Scan from the highest offset down so the nearest valid requester to
    // rr_ptr is the last (and therefore winning) assignment.
    always_comb begin
        winner       = '0;
        winner_valid = 1'b0;
        scan_idx     = '0;
        scan_sel     = '0;
        if (state_reg == ST_LOCKED) begin
            winner       = owner_reg;
            winner_valid = valid_pre_i[owner_reg];
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                scan_idx = {1'b0, rr_ptr_reg} + (SW + 1)'(i);
                if (scan_idx >= (SW + 1)'(N)) begin
                    scan_idx = scan_idx - (SW + 1)'(N);
                end
                scan_sel = scan_idx[SW-1:0];
                if (valid_pre_i[scan_sel]) begin
                    winner       = scan_sel;
                    winner_valid = 1'b1;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_ready
            assign ready_pre_o[gi] = reset_n & ~skid_valid_reg & winner_valid
                                   & (winner == SW'(gi)) & valid_pre_i[gi];
        end
    endgenerate

    always_comb begin
        acc_data = '0;
        acc_last = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (winner == SW'(k)) begin
                acc_data = data_i[k*DW +: DW];
                acc_last = last_pre_i[k];
            end
        end
    end

    assign accept = |(valid_pre_i & ready_pre_o);
    assign drain  = main_valid_reg & ready_post_i;

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        if (accept) begin
            if (acc_last) begin
                rr_ptr_next = (winner == SW'(N - 1)) ? '0 : winner + SW'(1);
            end
            case (state_reg)
                ST_IDLE: begin
                    if (!acc_last) begin
                        state_next = ST_LOCKED;
                        owner_next = winner;
                    end
                end
                ST_LOCKED: begin
                    if (acc_last) begin
                        state_next = ST_IDLE;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg  <= ST_IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // A beat can only arrive while the skid is empty, so the skid-full branch
    // never has to consider a concurrent accept.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_src_reg   <= '0;
            main_last_reg  <= 1'b0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            skid_src_reg   <= '0;
            skid_last_reg  <= 1'b0;
        end else if (skid_valid_reg) begin
            if (drain) begin
                main_valid_reg <= 1'b1;
                main_data_reg  <= skid_data_reg;
                main_src_reg   <= skid_src_reg;
                main_last_reg  <= skid_last_reg;
                skid_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_reg || drain) begin
                main_valid_reg <= 1'b1;
                main_data_reg  <= acc_data;
                main_src_reg   <= winner;
                main_last_reg  <= acc_last;
            end else begin
                skid_valid_reg <= 1'b1;
                skid_data_reg  <= acc_data;
                skid_src_reg   <= winner;
                skid_last_reg  <= acc_last;
            end
        end else if (drain) begin
            main_valid_reg <= 1'b0;
        end
    end

    assign valid_post_o = main_valid_reg;
    assign data_o       = main_data_reg;
    assign src_o        = main_src_reg;
    assign last_o       = main_last_reg;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Scoreboard bench for handshake_rr_arbiter: directed per-requester beat queues
// feed the DUT, hand-ordered expected beats are checked by an output monitor.
module tb_handshake_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    valid_pre_i;
    logic [N-1:0]    last_pre_i;
    logic [N*DW-1:0] data_i;
    logic [N-1:0]    ready_pre_o;
    logic            valid_post_o;
    logic [DW-1:0]   data_o;
    logic [SW-1:0]   src_o;
    logic            last_o;
    logic            ready_post_i;

    handshake_rr_arbiter #(.N(N), .DW(DW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .valid_pre_i  (valid_pre_i),
        .last_pre_i   (last_pre_i),
        .data_i       (data_i),
        .ready_pre_o  (ready_pre_o),
        .valid_post_o (valid_post_o),
        .data_o       (data_o),
        .src_o        (src_o),
        .last_o       (last_o),
        .ready_post_i (ready_post_i)
    );

    typedef struct packed {logic [7:0] d; logic l;} beat_t;
    typedef struct packed {logic [7:0] d; logic [1:0] s; logic l;} exp_t;

    beat_t src_q[N][$];
    exp_t  exp_q[$];
    int    checks   = 0;
    int    failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic push_beat(input int k, input logic [7:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        src_q[k].push_back(b);
    endtask

    task automatic expect_beat(input logic [7:0] d, input logic [1:0] s, input logic l);
        exp_t e;
        e.d = d;
        e.s = s;
        e.l = l;
        exp_q.push_back(e);
    endtask

    // Requester model: sample handshakes at negedge, retire at posedge+1,
    // present the next queue head at posedge+2.
    initial begin : driver
        logic [N-1:0] acc;
        valid_pre_i = '0;
        last_pre_i  = '0;
        data_i      = '0;
        forever begin
            @(negedge clk);
            acc = valid_pre_i & ready_pre_o;
            if (!reset_n) begin
                chk("ready_in_reset", ready_pre_o, 0);
            end else begin
                chk("ready_onehot_qualified",
                    ((ready_pre_o & (ready_pre_o - 1'b1)) != 0) || ((ready_pre_o & ~valid_pre_i) != 0), 0);
            end
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (acc[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
            end
            #1;
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() > 0) begin
                    valid_pre_i[k]       = 1'b1;
                    last_pre_i[k]        = src_q[k][0].l;
                    data_i[k*DW +: DW]   = src_q[k][0].d;
                end else begin
                    valid_pre_i[k]       = 1'b0;
                    last_pre_i[k]        = 1'b0;
                    data_i[k*DW +: DW]   = '0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && valid_post_o && ready_post_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual data=%0h src=%0d required no beat @%0t",
                             data_o, src_o, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", data_o, e.d);
                    chk("out_src", src_o, e.s);
                    chk("out_last", last_o, e.l);
                end
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        int left;
        n = 0;
        while (exp_q.size() > 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk({name, "_pending_expected"}, exp_q.size(), 0);
        left = 0;
        for (int k = 0; k < N; k++) left += src_q[k].size();
        chk({name, "_unsent_beats"}, left, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        for (int k = 0; k < N; k++) src_q[k].delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n      = 1'b1;
        ready_post_i = 1'b1;
    endtask

    initial begin : stimulus
        reset_n      = 1'b1;
        ready_post_i = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk("reset_valid_post", valid_post_o, 0);
        chk("reset_data", data_o, 0);
        chk("reset_src", src_o, 0);
        chk("reset_last", last_o, 0);
        chk("reset_ready_pre", ready_pre_o, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n      = 1'b1;
        ready_post_i = 1'b1;

        // Single requester 2 streaming 0..9: back-to-back, one cycle latency.
        @(posedge clk);
        #1;
        for (int j = 0; j < 10; j++) begin
            push_beat(2, 8'(j), 1'b1);
            expect_beat(8'(j), 2'd2, 1'b1);
        end
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("single_ready", ready_pre_o, 4'b0100);
            chk("single_valid_post", valid_post_o, (j != 0));
        end
        wait_drain("single");

        // Fairness: all four requesters with three single-beat packets each.
        do_reset();
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < N; k++) begin
                push_beat(k, 8'(16 * k + j), 1'b1);
                expect_beat(8'(16 * k + j), 2'(k), 1'b1);
            end
        end
        wait_drain("fair");

        // Packet lock: requester 1 grabs a 3-beat packet, then requester 0 joins.
        do_reset();
        push_beat(1, 8'h11, 1'b0);
        push_beat(1, 8'h12, 1'b0);
        push_beat(1, 8'h13, 1'b1);
        expect_beat(8'h11, 2'd1, 1'b0);
        expect_beat(8'h12, 2'd1, 1'b0);
        expect_beat(8'h13, 2'd1, 1'b1);
        expect_beat(8'h01, 2'd0, 1'b1);
        expect_beat(8'h02, 2'd0, 1'b1);
        @(posedge clk);
        #1;
        push_beat(0, 8'h01, 1'b1);
        push_beat(0, 8'h02, 1'b1);
        @(negedge clk);
        chk("lock_ready_beat2", ready_pre_o, 4'b0010);
        @(negedge clk);
        chk("lock_ready_beat3", ready_pre_o, 4'b0010);
        @(negedge clk);
        chk("lock_release_ready", ready_pre_o, 4'b0001);
        wait_drain("lock");

        // Backpressure: stall for three cycles with requester 3 streaming.
        do_reset();
        for (int j = 0; j < 6; j++) begin
            push_beat(3, 8'(8'hA0 + j), 1'b1);
            expect_beat(8'(8'hA0 + j), 2'd3, 1'b1);
        end
        @(posedge clk);
        #1;
        ready_post_i = 1'b0;
        @(negedge clk);
        chk("bp_stall1_data", data_o, 8'hA0);
        chk("bp_stall1_ready", ready_pre_o, 4'b1000);
        @(negedge clk);
        chk("bp_stall2_data", data_o, 8'hA0);
        chk("bp_stall2_ready", ready_pre_o, 4'b0000);
        @(negedge clk);
        chk("bp_stall3_data", data_o, 8'hA0);
        chk("bp_stall3_valid", valid_post_o, 1);
        chk("bp_stall3_ready", ready_pre_o, 4'b0000);
        @(posedge clk);
        #1;
        ready_post_i = 1'b1;
        wait_drain("bp");

        // Mixed packets under random backpressure; order is fixed by arbitration.
        do_reset();
        push_beat(0, 8'hE0, 1'b0);
        push_beat(0, 8'hE1, 1'b1);
        push_beat(0, 8'hE2, 1'b1);
        push_beat(1, 8'hF0, 1'b0);
        push_beat(1, 8'hF1, 1'b0);
        push_beat(1, 8'hF2, 1'b1);
        push_beat(2, 8'h90, 1'b1);
        push_beat(3, 8'hB0, 1'b0);
        push_beat(3, 8'hB1, 1'b1);
        expect_beat(8'hE0, 2'd0, 1'b0);
        expect_beat(8'hE1, 2'd0, 1'b1);
        expect_beat(8'hF0, 2'd1, 1'b0);
        expect_beat(8'hF1, 2'd1, 1'b0);
        expect_beat(8'hF2, 2'd1, 1'b1);
        expect_beat(8'h90, 2'd2, 1'b1);
        expect_beat(8'hB0, 2'd3, 1'b0);
        expect_beat(8'hB1, 2'd3, 1'b1);
        expect_beat(8'hE2, 2'd0, 1'b1);
        for (int n = 0; n < 400 && exp_q.size() > 0; n++) begin
            @(posedge clk);
            #1;
            ready_post_i = 1'($urandom_range(0, 1));
        end
        ready_post_i = 1'b1;
        wait_drain("mixed");

        // Reset while locked with main and skid both full.
        do_reset();
        ready_post_i = 1'b0;
        push_beat(1, 8'hC0, 1'b0);
        push_beat(1, 8'hC1, 1'b0);
        push_beat(1, 8'hC2, 1'b0);
        push_beat(1, 8'hC3, 1'b1);
        repeat (3) @(negedge clk);
        chk("rst_mid_full_valid", valid_post_o, 1);
        chk("rst_mid_full_ready", ready_pre_o, 4'b0000);
        #1;
        reset_n = 1'b0;
        for (int k = 0; k < N; k++) src_q[k].delete();
        #1;
        chk("rst_mid_valid_post", valid_post_o, 0);
        chk("rst_mid_ready_pre", ready_pre_o, 4'b0000);
        chk("rst_mid_data", data_o, 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n      = 1'b1;
        ready_post_i = 1'b1;
        push_beat(1, 8'hD1, 1'b1);
        push_beat(0, 8'hD0, 1'b1);
        expect_beat(8'hD0, 2'd0, 1'b1);
        expect_beat(8'hD1, 2'd1, 1'b1);
        wait_drain("rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
